// File: rtl/single_argmax_reader.sv
// Argmax reader: captures a vector of IEEE-754 singles on done_in, scans one element per clock, reports index/value of the largest.
// Latency: done_in to valid = HEIGHT cycles; back-to-back period HEIGHT+1 (done_in accepted in the IDLE cycle after REPORT).
// Backpressure: none; done_in while busy is dropped and latches sticky overrun. Optional macro SINGLE_ARGMAX_RELU_EN clamps negatives to +0.
// Ports: clk, rstn (async active-low), done_in, vector_in[HEIGHT] -> busy, valid, max_index, max_value, nan_seen, overrun.
module single_argmax_reader #(
   parameter int HEIGHT = 50,
   parameter int IDX_W  = $clog2(HEIGHT)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             done_in,
   input  logic [31:0]      vector_in [HEIGHT],
   output logic             busy,
   output logic             valid,
   output logic [IDX_W-1:0] max_index,
   output logic [31:0]      max_value,
   output logic             nan_seen,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   state_t            state_q, state_d;
   logic [31:0]       buf_q [HEIGHT];
   logic [IDX_W-1:0]  cnt_q;
   logic [31:0]       cand_val_q;
   logic [IDX_W-1:0]  cand_idx_q;
   logic              cand_vld_q;   // 0 while every element seen so far is NaN
   logic              nan_q;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Sign-magnitude ordering on raw bits; +0 and -0 compare equal.
   function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
      logic res;
      res = 1'b0;
      if (!a[31] && b[31])
         res = !((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
      else if (!a[31] && !b[31])
         res = a[30:0] > b[30:0];
      else if (a[31] && b[31])
         res = a[30:0] < b[30:0];
      return res;
   endfunction

   // Element conditioning applied once at capture so the scan sees final values.
   function automatic logic [31:0] prep(input logic [31:0] x);
`ifdef SINGLE_ARGMAX_RELU_EN
      return (x[31] && !is_nan(x)) ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   logic last;
   assign last = (cnt_q == IDX_W'(HEIGHT - 1));

   // FSM: state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state and status outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      valid   = 1'b0;
      case (state_q)
         IDLE:   if (done_in) state_d = SCAN;
         SCAN: begin
            busy = 1'b1;
            if (last) state_d = REPORT;
         end
         REPORT: begin
            busy    = 1'b1;
            valid   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // One compare step against the element addressed by the counter.
   logic [31:0]      elem;
   logic             elem_nan;
   logic             take;
   logic [31:0]      cand_val_d;
   logic [IDX_W-1:0] cand_idx_d;
   logic             cand_vld_d;

   always_comb begin
      elem       = buf_q[cnt_q];
      elem_nan   = is_nan(elem);
      take       = !elem_nan && (!cand_vld_q || fp_gt(elem, cand_val_q));
      cand_val_d = take ? elem  : cand_val_q;
      cand_idx_d = take ? cnt_q : cand_idx_q;
      cand_vld_d = cand_vld_q | take;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < HEIGHT; i++) buf_q[i] <= 32'h0;
         cnt_q      <= '0;
         cand_val_q <= 32'h0;
         cand_idx_q <= '0;
         cand_vld_q <= 1'b0;
         nan_q      <= 1'b0;
         max_index  <= '0;
         max_value  <= 32'h0;
         nan_seen   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (done_in && state_q != IDLE) overrun <= 1'b1;

         if (state_q == IDLE && done_in) begin
            for (int i = 0; i < HEIGHT; i++) buf_q[i] <= prep(vector_in[i]);
            cand_val_q <= prep(vector_in[0]);
            cand_idx_q <= '0;
            cand_vld_q <= !is_nan(vector_in[0]);
            nan_q      <= is_nan(vector_in[0]);
            cnt_q      <= IDX_W'(1);
         end else if (state_q == SCAN) begin
            cand_val_q <= cand_val_d;
            cand_idx_q <= cand_idx_d;
            cand_vld_q <= cand_vld_d;
            nan_q      <= nan_q | elem_nan;
            cnt_q      <= cnt_q + IDX_W'(1);
            // Results land on the SCAN->REPORT edge so they are visible with valid.
            if (last) begin
               max_index <= cand_vld_d ? cand_idx_d : '0;
               max_value <= cand_vld_d ? cand_val_d : QNAN;
               nan_seen  <= nan_q | elem_nan;
            end
         end
      end
   end

endmodule

// File: tb/tb_single_argmax_reader.sv
// Bench for single_argmax_reader (HEIGHT=10): directed corner vectors plus randomized vectors against an ordering-key model.
// Latency checked cycle by cycle: busy on C+1..C+10, valid only at C+10.
// Also covers overrun on a mid-scan done_in, back-to-back acceptance and async reset mid-scan.
module tb_single_argmax_reader;
   localparam int H = 10;
   localparam int IW = $clog2(H);

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          done_in = 1'b0;
   logic [31:0]   vector_in [H];
   logic          busy, valid, nan_seen, overrun;
   logic [IW-1:0] max_index;
   logic [31:0]   max_value;

   int n_chk  = 0;
   int n_fail = 0;

   logic        exp_ovr = 1'b0;
   logic [31:0] snap [H];
   int          last_idx = 0;
   logic [31:0] last_val = 32'h0;
   logic        last_nan = 1'b0;

   always #5 clk = ~clk;

   single_argmax_reader #(.HEIGHT(H), .IDX_W(IW)) dut (
      .clk(clk), .rstn(rstn), .done_in(done_in), .vector_in(vector_in),
      .busy(busy), .valid(valid), .max_index(max_index), .max_value(max_value),
      .nan_seen(nan_seen), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic isnan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   // Reference: map each non-NaN single to a signed integer whose ordering matches
   // the float ordering (+0 and -0 both map to 0), then take the first maximum.
   task automatic model(output int idx, output logic [31:0] val, output logic nan);
      int best, bkey, key;
      logic [31:0] x;
      best = -1; bkey = 0; nan = 1'b0;
      idx = 0; val = 32'h7FC00000;
      for (int i = 0; i < H; i++) begin
         x = snap[i];
`ifdef SINGLE_ARGMAX_RELU_EN
         if (x[31] && !isnan(x)) x = 32'h0;
`endif
         if (isnan(x)) begin
            nan = 1'b1;
         end else begin
            key = x[31] ? -int'({1'b0, x[30:0]}) : int'({1'b0, x[30:0]});
            if (best < 0 || key > bkey) begin
               best = i; bkey = key; idx = i; val = x;
            end
         end
      end
   endtask

   // Drives done_in with the current vector_in and follows the scan for HEIGHT cycles.
   // ovr_at (1..H-1) injects a second done_in and scrambles the input in that cycle.
   task automatic run_scan(input string tag, input int ovr_at);
      int e_idx;
      logic [31:0] e_val;
      logic e_nan;
      @(negedge clk);
      for (int i = 0; i < H; i++) snap[i] = vector_in[i];
      model(e_idx, e_val, e_nan);
      done_in = 1'b1;
      for (int n = 1; n <= H; n++) begin
         @(negedge clk);
         done_in = (n == ovr_at);
         if (n == ovr_at) begin
            exp_ovr = 1'b1;
            for (int i = 0; i < H; i++) vector_in[i] = $urandom;
         end
         chk({tag, ".busy"}, 32'(busy), 32'd1);
         chk({tag, ".valid"}, 32'(valid), 32'(n == H));
      end
      chk({tag, ".index"}, 32'(max_index), 32'(e_idx));
      chk({tag, ".value"}, max_value, e_val);
      chk({tag, ".nan"}, 32'(nan_seen), 32'(e_nan));
      chk({tag, ".ovr"}, 32'(overrun), 32'(exp_ovr));
      last_idx = e_idx; last_val = e_val; last_nan = e_nan;
   endtask

   task automatic idle_hold(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         chk("hold.valid", 32'(valid), 32'd0);
         chk("hold.busy", 32'(busy), 32'd0);
      end
      chk("hold.index", 32'(max_index), 32'(last_idx));
      chk("hold.value", max_value, last_val);
      chk("hold.nan", 32'(nan_seen), 32'(last_nan));
   endtask

   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < H; i++) vector_in[i] = v;
   endtask

   function automatic logic [31:0] rnd_elem(input logic [31:0] prev);
      logic s;
      s = 1'($urandom);
      case ($urandom_range(0, 9))
         0: return {s, 8'hFF, 23'($urandom) | 23'd1};
         1: return {s, 8'hFF, 23'd0};
         2: return {s, 31'd0};
         3: return prev;
         4, 5: return {s, 8'($urandom_range(126, 128)), 23'($urandom_range(0, 2))};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      fill(32'h0);
      #2 rstn = 1'b0;
      #1;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.valid", 32'(valid), 32'd0);
      chk("rst.index", 32'(max_index), 32'd0);
      chk("rst.value", max_value, 32'h0);
      chk("rst.nan", 32'(nan_seen), 32'd0);
      chk("rst.ovr", 32'(overrun), 32'd0);
      #10 rstn = 1'b1;

      // Ascending 1.0 .. 10.0
      vector_in = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
      run_scan("asc", 0);
      idle_hold(3);

      // All -1.0 except element 4 = -0.5
      fill(32'hBF800000); vector_in[4] = 32'hBF000000;
      run_scan("neg", 0);

      // Tie between elements 2 and 7
      fill(32'h3F800000); vector_in[2] = 32'h40400000; vector_in[7] = 32'h40400000;
      run_scan("tie", 0);

      // -0 vs +0
      fill(32'hBF800000); vector_in[0] = 32'h80000000; vector_in[1] = 32'h00000000;
      run_scan("zero", 0);

      // NaN at element 0, +Inf at 5
      fill(32'h3F000000); vector_in[0] = 32'h7FC00000; vector_in[5] = 32'h7F800000;
      run_scan("naninf", 0);

      // All NaN
      fill(32'h7FC00000); vector_in[3] = 32'hFFC00001;
      run_scan("allnan", 0);

      // -Inf everywhere except a negative NaN
      fill(32'hFF800000); vector_in[6] = 32'hFF800001;
      run_scan("ninf", 0);
      idle_hold(2);

      // Overrun mid-scan, then back-to-back acceptance
      vector_in = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
      run_scan("ovr", 3);
      fill(32'h3F800000); vector_in[8] = 32'h40E00000;
      run_scan("b2b", 0);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] p;
         p = $urandom;
         for (int i = 0; i < H; i++) begin
            p = rnd_elem(p);
            vector_in[i] = p;
         end
         run_scan("rnd", ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, H - 1)) : 0);
      end

      // Async reset in cycle C+5 abandons the scan
      @(negedge clk);
      fill(32'h40000000);
      done_in = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         done_in = 1'b0;
      end
      rstn = 1'b0;
      #1;
      chk("mrst.busy", 32'(busy), 32'd0);
      chk("mrst.valid", 32'(valid), 32'd0);
      chk("mrst.index", 32'(max_index), 32'd0);
      chk("mrst.value", max_value, 32'h0);
      chk("mrst.nan", 32'(nan_seen), 32'd0);
      chk("mrst.ovr", 32'(overrun), 32'd0);
      exp_ovr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      last_idx = 0; last_val = 32'h0; last_nan = 1'b0;
      idle_hold(12);

      fill(32'hC0000000); vector_in[9] = 32'h3E800000; vector_in[1] = 32'h7FC00000;
      run_scan("post", 0);
      idle_hold(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
